// File: rtl/rs_dispatch.sv
// rtl/rs_dispatch.sv - in-order dispatch FIFO driving up to 8 reservation stations
//
// Decoded instructions are queued in a small FIFO and issued strictly in order.
// The head entry goes to the station named by its unit-type field.
// The unit-type field is the top unitTypeBits of the word, so word bit queueWidth-1 is the field MSB.
//
// Ports:
//   clock_i          rising-edge clock
//   reset_i          asynchronous active-low reset
//   enable_i         decode presents a valid instruction
//   instruction_i    decoded instruction word
//   flush_i          synchronous pipeline flush
//   stall_o          FIFO full; decode must hold its instruction
//   rsStall_i        per-station stall, bit k = station k
//   rsEnable_o       registered one-hot dispatch strobe
//   rsInstruction_o  instruction bus shared by all stations
//   badUnit_o        one-cycle pulse when an illegal unit type is dropped
//   occupancy_o      current FIFO entry count
//   dispatchCount_o  instructions dispatched since reset (wraps)

module rs_dispatch #(
  parameter int queueWidth       = 302,
  parameter int numRS            = 4,
  parameter int unitTypeBits     = 3,
  parameter int fifoDepth        = 4,
  parameter int fifoIdxBits      = 2,
  parameter int DispatchInstance = 0
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic [queueWidth-1:0]  instruction_i,
  input  logic                   flush_i,
  output logic                   stall_o,
  input  logic [numRS-1:0]       rsStall_i,
  output logic [numRS-1:0]       rsEnable_o,
  output logic [queueWidth-1:0]  rsInstruction_o,
  output logic                   badUnit_o,
  output logic [fifoIdxBits:0]   occupancy_o,
  output logic [31:0]            dispatchCount_o
);

  if (numRS < 1 || numRS > 8 || numRS > (1 << unitTypeBits) ||
      DispatchInstance < 0 || DispatchInstance > 7 ||
      fifoDepth < 2 || fifoDepth != (1 << fifoIdxBits)) begin : g_param_check
    $error("rs_dispatch: illegal parameter combination");
  end

  logic [queueWidth-1:0]   mem [fifoDepth];
  logic [fifoIdxBits-1:0]  wr_ptr;
  logic [fifoIdxBits-1:0]  rd_ptr;
  logic [fifoIdxBits:0]    count;

  logic [queueWidth-1:0]   head;
  logic [unitTypeBits-1:0] unit;
  logic                    unit_ok;
  logic                    unit_stall;
  logic [numRS-1:0]        unit_onehot;
  logic                    full;
  logic                    has_head;
  logic                    push;
  logic                    pop;
  logic                    dispatch;

  assign head = mem[rd_ptr];
  assign unit = head[queueWidth-1 -: unitTypeBits];

  // Decode the unit type against the attached stations; anything outside
  // 0..numRS-1 leaves unit_ok low and is dropped as a bad unit.
  always_comb begin
    unit_ok     = 1'b0;
    unit_stall  = 1'b0;
    unit_onehot = '0;
    for (int k = 0; k < numRS; k++) begin
      if (unit == unitTypeBits'(k)) begin
        unit_ok        = 1'b1;
        unit_stall     = rsStall_i[k];
        unit_onehot[k] = 1'b1;
      end
    end
  end

  assign full     = (count == (fifoIdxBits+1)'(fifoDepth));
  assign has_head = (count != '0) && !flush_i;
  // A stalled legal head blocks the whole queue; bad units never wait.
  assign pop      = has_head && (!unit_ok || !unit_stall);
  assign dispatch = has_head && unit_ok && !unit_stall;
  // Full blocks the push even when a pop frees a slot on the same edge.
  assign push     = enable_i && !full && !flush_i;

  always_ff @(posedge clock_i) begin
    if (push) begin
      mem[wr_ptr] <= instruction_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      rsEnable_o      <= '0;
      rsInstruction_o <= '0;
      badUnit_o       <= 1'b0;
      dispatchCount_o <= '0;
    end else if (flush_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rsEnable_o <= '0;
      badUnit_o  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + fifoIdxBits'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + fifoIdxBits'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (fifoIdxBits+1)'(1);
        2'b01:   count <= count - (fifoIdxBits+1)'(1);
        default: count <= count;
      endcase
      rsEnable_o <= dispatch ? unit_onehot : '0;
      badUnit_o  <= pop && !unit_ok;
      if (dispatch) begin
        rsInstruction_o <= head;
        dispatchCount_o <= dispatchCount_o + 32'd1;
      end
    end
  end

  assign stall_o     = full;
  assign occupancy_o = count;

endmodule

// File: tb/tb_rs_dispatch.sv
// tb/tb_rs_dispatch.sv - directed table-driven bench for rs_dispatch
module tb_rs_dispatch;

  localparam int QW = 302;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          enable_i;
  logic [QW-1:0] instruction_i;
  logic          flush_i;
  logic          stall_o;
  logic [3:0]    rsStall_i;
  logic [3:0]    rsEnable_o;
  logic [QW-1:0] rsInstruction_o;
  logic          badUnit_o;
  logic [2:0]    occupancy_o;
  logic [31:0]   dispatchCount_o;

  int total = 0;
  int bad   = 0;

  rs_dispatch #(
    .queueWidth(QW), .numRS(4), .unitTypeBits(3),
    .fifoDepth(4), .fifoIdxBits(2), .DispatchInstance(0)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i),
    .instruction_i(instruction_i), .flush_i(flush_i), .stall_o(stall_o),
    .rsStall_i(rsStall_i), .rsEnable_o(rsEnable_o),
    .rsInstruction_o(rsInstruction_o), .badUnit_o(badUnit_o),
    .occupancy_o(occupancy_o), .dispatchCount_o(dispatchCount_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic       en;
    logic [2:0] t;
    int         tag;
    logic       fl;
    logic [3:0] rss;
    logic [3:0] e_en;
    logic [2:0] e_t;
    int         e_tag;
    logic       e_bad;
    logic [2:0] e_occ;
    logic       e_full;
    int         e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [QW-1:0] mk(input logic [2:0] t, input int tag);
    logic [QW-1:0] w;
    w = '0;
    w[QW-1 -: 3] = t;
    w[31:0] = tag;
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [QW-1:0] exp);
    total++;
    if (rsInstruction_o !== exp) begin
      bad++;
      $display("FAIL %s: got t=%0d tag=%0h expected t=%0d tag=%0h", name,
               rsInstruction_o[QW-1 -: 3], rsInstruction_o[31:0], exp[QW-1 -: 3], exp[31:0]);
    end
  endtask

  task automatic tick;
    @(posedge clock_i);
    #1;
  endtask

  task automatic chk_all(input string name, input logic [3:0] e_en, input logic [QW-1:0] e_w,
                         input logic e_bad, input logic [2:0] e_occ, input logic e_full,
                         input int e_cnt);
    chk({name, ".rsEnable"}, 32'(rsEnable_o), 32'(e_en));
    chk_w({name, ".rsInstruction"}, e_w);
    chk({name, ".badUnit"}, 32'(badUnit_o), 32'(e_bad));
    chk({name, ".occupancy"}, 32'(occupancy_o), 32'(e_occ));
    chk({name, ".stall"}, 32'(stall_o), 32'(e_full));
    chk({name, ".dispatchCount"}, dispatchCount_o, e_cnt);
  endtask

  initial begin
    reset_i = 1'b0; enable_i = 1'b0; instruction_i = '0; flush_i = 1'b0; rsStall_i = '0;

    //           en t tag fl rss     e_en    e_t tag bad occ full cnt
    vecs.push_back('{1, 2, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 4'b0000, 4'b0100, 2, 1, 0, 0, 0, 1});
    vecs.push_back('{1, 0, 2, 0, 4'b0001, 4'b0000, 2, 1, 0, 1, 0, 1});
    vecs.push_back('{1, 0, 3, 0, 4'b0001, 4'b0000, 2, 1, 0, 2, 0, 1});
    vecs.push_back('{1, 0, 4, 0, 4'b0001, 4'b0000, 2, 1, 0, 3, 0, 1});
    vecs.push_back('{1, 0, 5, 0, 4'b0001, 4'b0000, 2, 1, 0, 4, 1, 1});
    vecs.push_back('{1, 0, 6, 0, 4'b0001, 4'b0000, 2, 1, 0, 4, 1, 1}); // full: ignored
    vecs.push_back('{1, 0, 6, 0, 4'b0000, 4'b0001, 0, 2, 0, 3, 0, 2}); // pop, no push while full
    vecs.push_back('{1, 0, 6, 0, 4'b0000, 4'b0001, 0, 3, 0, 3, 0, 3}); // push+pop
    vecs.push_back('{0, 0, 0, 0, 4'b0000, 4'b0001, 0, 4, 0, 2, 0, 4});
    vecs.push_back('{0, 0, 0, 0, 4'b0000, 4'b0001, 0, 5, 0, 1, 0, 5});
    vecs.push_back('{0, 0, 0, 0, 4'b0000, 4'b0001, 0, 6, 0, 0, 0, 6});
    vecs.push_back('{1, 5, 7, 0, 4'b0000, 4'b0000, 0, 6, 0, 1, 0, 6});
    vecs.push_back('{1, 1, 8, 0, 4'b0000, 4'b0000, 0, 6, 1, 1, 0, 6}); // bad unit dropped
    vecs.push_back('{0, 0, 0, 0, 4'b0000, 4'b0010, 1, 8, 0, 0, 0, 7});
    vecs.push_back('{1, 3, 9, 0, 4'b1000, 4'b0000, 1, 8, 0, 1, 0, 7});
    vecs.push_back('{1, 0, 10, 0, 4'b1000, 4'b0000, 1, 8, 0, 2, 0, 7});
    vecs.push_back('{0, 0, 0, 0, 4'b1000, 4'b0000, 1, 8, 0, 2, 0, 7}); // no bypass
    vecs.push_back('{1, 0, 11, 1, 4'b0000, 4'b0000, 1, 8, 0, 0, 0, 7}); // flush
    vecs.push_back('{0, 0, 0, 0, 4'b0000, 4'b0000, 1, 8, 0, 0, 0, 7});

    tick; tick;
    reset_i = 1'b1;
    #1;
    chk_all("reset", 4'b0000, '0, 1'b0, 3'd0, 1'b0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      enable_i      = vecs[i].en;
      instruction_i = mk(vecs[i].t, vecs[i].tag);
      flush_i       = vecs[i].fl;
      rsStall_i     = vecs[i].rss;
      tick;
      chk_all($sformatf("vec%0d", i), vecs[i].e_en, mk(vecs[i].e_t, vecs[i].e_tag),
              vecs[i].e_bad, vecs[i].e_occ, vecs[i].e_full, vecs[i].e_cnt);
    end

    // Streaming to station 1: one entry in flight, pointers wrap several times.
    enable_i = 1'b1; flush_i = 1'b0; rsStall_i = '0;
    instruction_i = mk(1, 100);
    tick;
    chk("stream.prime.occ", 32'(occupancy_o), 1);
    for (int i = 1; i <= 10; i++) begin
      instruction_i = mk(1, 100 + i);
      tick;
      chk_all($sformatf("stream%0d", i), 4'b0010, mk(1, 100 + i - 1), 1'b0, 3'd1, 1'b0, 7 + i);
    end

    // Asynchronous reset mid-stream: strobe must drop before the next edge.
    #2;
    reset_i = 1'b0;
    #1;
    chk_all("async_reset", 4'b0000, '0, 1'b0, 3'd0, 1'b0, 0);
    tick; tick;
    reset_i = 1'b1;
    enable_i = 1'b1;
    instruction_i = mk(2, 200);
    tick;
    chk_all("post_reset.push", 4'b0000, '0, 1'b0, 3'd1, 1'b0, 0);
    enable_i = 1'b0;
    tick;
    chk_all("post_reset.pop", 4'b0100, mk(2, 200), 1'b0, 3'd0, 1'b0, 1);
    tick;
    chk("post_reset.strobe_one_cycle", 32'(rsEnable_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs_dispatch.md
Name: rs_dispatch

Overview:
- In-order dispatch transmitter that drives the instruction/enable/stall interface of up to 8 reservation stations.
- Accepts decoded instruction words from the decode stage into a small FIFO.
- Routes each head instruction to the target station selected by its unit-type field, honouring each station's stall.
- Sits between decode and the reservation station array in the out-of-order backend.

Parameters:
- queueWidth, 302, instruction word width (matches reservation station input).
- numRS, 4, number of attached reservation stations (1..8).
- unitTypeBits, 3, width of the unit-type field at instruction bits [0:unitTypeBits-1] (MSB-first indexing).
- fifoDepth, 4, FIFO entries (power of 2, >=2).
- fifoIdxBits, 2, log2(fifoDepth).
- DispatchInstance, 0, instance number, 0..7.

Ports:
- clock_i  in  1  clock, rising edge.
- reset_i  in  1  reset, asynchronous, active-low.
- enable_i  in  1  decode presents a valid instruction this cycle.
- instruction_i  in  queueWidth  decoded instruction word.
- flush_i  in  1  synchronous pipeline flush.
- stall_o  out  1  backpressure to decode; FIFO full.
- rsStall_i  in  numRS  per-station stall; bit k = station k cannot accept.
- rsEnable_o  out  numRS  one-hot dispatch strobe; bit k = station k.
- rsInstruction_o  out  queueWidth  instruction bus shared by all stations.
- badUnit_o  out  1  one-cycle pulse when an instruction with an illegal unit type is discarded.
- occupancy_o  out  fifoIdxBits+1  current FIFO entry count.
- dispatchCount_o  out  32  count of instructions dispatched since reset.

Behaviour:
- Reset (reset_i low, asynchronous): FIFO empty, read/write pointers 0, count 0.
  - Outputs: rsEnable_o=0, rsInstruction_o=0, badUnit_o=0, dispatchCount_o=0, stall_o=0, occupancy_o=0.
  - Reset mid-operation discards all queued instructions; any strobe in flight is deasserted immediately.
- stall_o is combinational: (count == fifoDepth).
- Push: on a rising edge with enable_i=1, stall_o=0 and flush_i=0, instruction_i is written at the write pointer; the write pointer increments modulo fifoDepth.
  - enable_i while stall_o=1 is ignored; decode must hold the instruction.
  - No push when full, even if a pop occurs in the same cycle.
- Pop/dispatch decision uses the head entry when count>0 and flush_i=0. Let t = head[0:unitTypeBits-1].
  - t < numRS and rsStall_i[t]=0: next edge sets rsEnable_o = one-hot(t), rsInstruction_o = head; pop; dispatchCount_o += 1 (wraps at 2^32).
  - t < numRS and rsStall_i[t]=1: no pop; rsEnable_o=0; rsInstruction_o holds its last value. Strict head-of-line blocking; younger entries never bypass.
  - t >= numRS: pop; rsEnable_o=0; badUnit_o=1 for one cycle; dispatchCount_o unchanged.
  - Empty FIFO: rsEnable_o=0, badUnit_o=0.
- rsEnable_o is registered and high for exactly one cycle per dispatch. Back-to-back dispatches to the same or different stations are allowed every cycle.
- Latency: an instruction pushed at edge N into an empty FIFO is dispatched with rsEnable_o high after edge N+1. There is no same-cycle bypass.
- Simultaneous push and pop (not full): both occur; count is unchanged.
- Flush (flush_i=1 at an edge): pointers and count go to 0, rsEnable_o=0, badUnit_o=0. A push or pop in that cycle is suppressed. dispatchCount_o is retained.
- Pointer wrap: pointers wrap modulo fifoDepth; count alone distinguishes full from empty.
- occupancy_o equals count after each edge.

Test Plan:
- Reset low for 2 cycles, then release -> all outputs 0, stall_o=0, occupancy_o=0.
- Push one instruction with t=2 at edge 0, rsStall_i=0 -> after edge 1: rsEnable_o=4'b0100, rsInstruction_o=pushed word, dispatchCount_o=1, occupancy_o=0.
- rsStall_i=4'b0001 held; push 4 instructions with t=0, then assert enable_i again -> occupancy_o=4, stall_o=1, fifth word not accepted, rsEnable_o stays 0.
  - Release rsStall_i -> four consecutive cycles of rsEnable_o=4'b0001 in push order; stall_o drops after the first pop.
- Push t=5 (numRS=4), then t=1 -> one cycle badUnit_o=1 with rsEnable_o=0, next cycle rsEnable_o=4'b0010; dispatchCount_o increments by 1 only.
- Head t=3 with rsStall_i[3]=1, next entry t=0 with rsStall_i[0]=0 -> no dispatch, no bypass, occupancy_o=2.
  - Then flush_i for 1 cycle -> occupancy_o=0, no strobe, dispatchCount_o unchanged.
- Continuous push+pop for 10 cycles to station 1 -> 10 strobes, occupancy steady at 1, pointers wrap correctly.
  - Then drop reset_i mid-stream -> rsEnable_o=0 asynchronously, counters cleared.
